// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift
// window, emitting one registered z1..z9 window per interior pixel.
module window_3x3_gen #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 21,
    parameter int IMG_H = 11,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] z1,
    output logic [PIX_W-1:0] z2,
    output logic [PIX_W-1:0] z3,
    output logic [PIX_W-1:0] z4,
    output logic [PIX_W-1:0] z5,
    output logic [PIX_W-1:0] z6,
    output logic [PIX_W-1:0] z7,
    output logic [PIX_W-1:0] z8,
    output logic [PIX_W-1:0] z9,
    output logic             win_valid,
    output logic [RW-1:0]    win_row,
    output logic [CW-1:0]    win_col,
    output logic             win_last,
    output logic             frame_done
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACTIVE,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] col_reg, col_next, eff_col;
    logic [RW-1:0] row_reg, row_next, eff_row;
    logic          start, accept, emit, at_eol, at_last;

    logic [PIX_W-1:0] line1_mem [IMG_W];
    logic [PIX_W-1:0] line2_mem [IMG_W];
    logic [PIX_W-1:0] l1_rd, l2_rd;

    logic [PIX_W-1:0] sh_reg   [9];
    logic [PIX_W-1:0] win_next [9];
    logic [PIX_W-1:0] win_reg  [9];
    logic [PIX_W-1:0] new_col  [3];

    logic          win_valid_reg, win_last_reg;
    logic [RW-1:0] win_row_reg;
    logic [CW-1:0] win_col_reg;

    // A qualified sof always restarts at (0,0), whatever the current state.
    always_comb begin
        start      = pix_valid && sof;
        accept     = start || (pix_valid && (state_reg == ACTIVE));
        eff_col    = start ? '0 : col_reg;
        eff_row    = start ? '0 : row_reg;
        at_eol     = (eff_col == COL_LAST);
        at_last    = at_eol && (eff_row == ROW_LAST);
        emit       = accept && (eff_row >= RW'(2)) && (eff_col >= CW'(2));

        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        if (accept) begin
            state_next = at_last ? DONE : ACTIVE;
            if (at_eol) begin
                col_next = '0;
                row_next = at_last ? '0 : eff_row + RW'(1);
            end else begin
                col_next = eff_col + CW'(1);
                row_next = eff_row;
            end
        end
    end

    // Asynchronous read so the old contents are seen in the same cycle they are overwritten.
    assign l1_rd = line1_mem[eff_col];
    assign l2_rd = line2_mem[eff_col];

    always_ff @(posedge clk) begin
        if (accept) begin
            line1_mem[eff_col] <= pix_in;
            line2_mem[eff_col] <= l1_rd;
        end
    end

    always_comb begin
        new_col[0] = l2_rd;
        new_col[1] = l1_rd;
        new_col[2] = pix_in;
        for (int i = 0; i < 3; i++) begin
            win_next[3*i]     = sh_reg[3*i+1];
            win_next[3*i + 1] = sh_reg[3*i+2];
            win_next[3*i + 2] = new_col[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= WAIT_SOF;
            col_reg   <= '0;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
        end
    end

    // The shift window tracks every accepted pixel; the output copy only loads on emit.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++) begin
                sh_reg[i]  <= '0;
                win_reg[i] <= '0;
            end
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            win_row_reg   <= '0;
            win_col_reg   <= '0;
        end else begin
            win_valid_reg <= 1'b0;
            win_last_reg  <= 1'b0;
            if (accept) begin
                for (int i = 0; i < 9; i++) begin
                    sh_reg[i] <= win_next[i];
                end
            end
            if (emit) begin
                for (int i = 0; i < 9; i++) begin
                    win_reg[i] <= win_next[i];
                end
                win_valid_reg <= 1'b1;
                win_last_reg  <= at_last;
                win_row_reg   <= eff_row - RW'(1);
                win_col_reg   <= eff_col - CW'(1);
            end
        end
    end

    assign z1 = win_reg[0];
    assign z2 = win_reg[1];
    assign z3 = win_reg[2];
    assign z4 = win_reg[3];
    assign z5 = win_reg[4];
    assign z6 = win_reg[5];
    assign z7 = win_reg[6];
    assign z8 = win_reg[7];
    assign z9 = win_reg[8];

    assign win_valid  = win_valid_reg;
    assign win_last   = win_last_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign frame_done = (state_reg == DONE);

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: ramp and constant frames, gaps, mid-frame
// sof, mid-frame reset and post-frame pixel rejection.
module tb_window_3x3_gen;

    localparam int PIX_W = 8;
    localparam int IMG_W = 21;
    localparam int IMG_H = 11;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_valid = 1'b0;
    logic             sof = 1'b0;
    logic [PIX_W-1:0] z1, z2, z3, z4, z5, z6, z7, z8, z9;
    logic             win_valid, win_last, frame_done;
    logic [RW-1:0]    win_row;
    logic [CW-1:0]    win_col;
    logic [71:0]      zpack;

    int n_vec = 0;
    int n_err = 0;
    int obs_win = 0;
    logic [71:0] hold_z = '0;
    int hold_r = 0;
    int hold_c = 0;

    window_3x3_gen #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .z1(z1), .z2(z2), .z3(z3), .z4(z4), .z5(z5), .z6(z6), .z7(z7), .z8(z8), .z9(z9),
        .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
        .win_last(win_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    assign zpack = {z1, z2, z3, z4, z5, z6, z7, z8, z9};

    function automatic logic [7:0] pval(input int mode, input int r, input int c);
        int v;
        v = (mode == 0) ? (r * IMG_W + c) % 256 : 8'h55;
        return 8'(v);
    endfunction

    function automatic logic [71:0] win_exp(input int mode, input int r, input int c);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[71 - 8*(3*i + j) -: 8] = pval(mode, r - 2 + i, c - 2 + j);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_hold();
        chk("hold_z", zpack, hold_z);
        chk("hold_row", 72'(win_row), 72'(hold_r));
        chk("hold_col", 72'(win_col), 72'(hold_c));
    endtask

    // Present one pixel, let it be accepted, then check the registered result.
    task automatic feed(input int r, input int c, input int mode, input bit s,
                        input bit en, input bit fd);
        bit exp_v;
        pix_valid = 1'b1;
        sof       = s;
        pix_in    = pval(mode, r, c);
        @(posedge clk); #1;
        exp_v = en && (r >= 2) && (c >= 2);
        if (win_valid) obs_win++;
        chk($sformatf("win_valid(%0d,%0d)", r, c), 72'(win_valid), 72'(exp_v));
        if (exp_v) begin
            hold_z = win_exp(mode, r, c);
            hold_r = r - 1;
            hold_c = c - 1;
            chk($sformatf("window(%0d,%0d)", r, c), zpack, hold_z);
            chk("win_row", 72'(win_row), 72'(hold_r));
            chk("win_col", 72'(win_col), 72'(hold_c));
            chk("win_last", 72'(win_last), 72'((r == IMG_H - 1) && (c == IMG_W - 1)));
        end else begin
            check_hold();
        end
        chk($sformatf("frame_done(%0d,%0d)", r, c), 72'(frame_done), 72'(fd));
    endtask

    task automatic gap(input int n);
        pix_valid = 1'b0;
        sof       = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("gap_win_valid", 72'(win_valid), 72'(0));
            check_hold();
        end
    endtask

    task automatic full_frame(input int mode, input bit gaps);
        int idx;
        idx = 0;
        obs_win = 0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                feed(r, c, mode, (r == 0) && (c == 0), 1'b1,
                     (r == IMG_H - 1) && (c == IMG_W - 1));
                if (mode == 0 && !gaps && r == 2 && c == 2)
                    chk("first_win", zpack, 72'h00_01_02_15_16_17_2A_2B_2C);
                if (mode == 0 && r == IMG_H - 1 && c == IMG_W - 1)
                    chk("last_z5", 72'(z5), 72'(208));
                if (gaps) gap((idx % 2 == 0) ? 1 : int'($urandom_range(1, 5)));
                idx++;
            end
        chk("window_count", 72'(obs_win), 72'(NWIN));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_win_valid", 72'(win_valid), 72'(0));
        chk("rst_z", zpack, 72'(0));
        chk("rst_row", 72'(win_row), 72'(0));
        chk("rst_col", 72'(win_col), 72'(0));
        chk("rst_last", 72'(win_last), 72'(0));
        chk("rst_frame_done", 72'(frame_done), 72'(0));
        rst = 1'b0;

        // Pixels before any sof are ignored.
        for (int k = 0; k < 5; k++) feed(3, 3, 0, 1'b0, 1'b0, 1'b0);

        full_frame(0, 1'b0);
        full_frame(0, 1'b1);

        // Abandon a ramp frame at (5,7) with a fresh constant frame.
        for (int r = 0; r <= 5; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r < 5 || c < 7) feed(r, c, 0, (r == 0) && (c == 0), 1'b1, 1'b0);
        full_frame(1, 1'b0);

        // Reset in the middle of a frame at pixel (4,4).
        for (int r = 0; r <= 4; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r < 4 || c < 4) feed(r, c, 0, (r == 0) && (c == 0), 1'b1, 1'b0);
        rst       = 1'b1;
        pix_valid = 1'b1;
        pix_in    = pval(0, 4, 4);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_win_valid", 72'(win_valid), 72'(0));
        chk("midrst_z", zpack, 72'(0));
        chk("midrst_row", 72'(win_row), 72'(0));
        chk("midrst_col", 72'(win_col), 72'(0));
        chk("midrst_frame_done", 72'(frame_done), 72'(0));
        hold_z = '0;
        hold_r = 0;
        hold_c = 0;
        obs_win = 0;
        for (int k = 5; k < 35; k++) feed(4, k % IMG_W, 0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_windows", 72'(obs_win), 72'(0));

        // Completed frame, then extra pixels without sof, then a normal frame.
        full_frame(0, 1'b0);
        obs_win = 0;
        for (int k = 0; k < 30; k++) feed(k / IMG_W, k % IMG_W, 0, 1'b0, 1'b0, 1'b1);
        chk("after_done_windows", 72'(obs_win), 72'(0));
        full_frame(0, 1'b0);
        gap(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
